uart_rx_control_module: RTL and testbench

//   UART receive controller: the receive end of the 8N1 serial link driven by the TX control block.

---
 rtl/uart_rx_control_module_if.sv | 20 ++
 rtl/uart_rx_control_module.sv | 134 +++++++++++++
 tb/tb_uart_rx_control_module.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_control_module_if.sv
// Bundles the receiver's control, serial input and byte-delivery signals for the UART RX controller.
// The master drives enable and line; the slave returns data, done, error and busy.
interface uart_rx_control_module_if;
    logic       RX_En_Sig;
    logic       RX_Pin_In;
    logic [7:0] RX_Data;
    logic       RX_Done_Sig;
    logic       RX_Err_Sig;
    logic       RX_Busy;

    modport master (
        output RX_En_Sig, RX_Pin_In,
        input  RX_Data, RX_Done_Sig, RX_Err_Sig, RX_Busy
    );

    modport slave (
        input  RX_En_Sig, RX_Pin_In,
        output RX_Data, RX_Done_Sig, RX_Err_Sig, RX_Busy
    );
endinterface

// File: rtl/uart_rx_control_module.sv
// UART 8N1 receiver (8E1/8O1 when UART_RX_PARITY_EN is defined); done pulses one cycle after the stop-bit mid sample.
// No backpressure: the consumer must take RX_Data on the done pulse; it is held until the next frame.
module uart_rx_control_module #(
    parameter int BPS_DIV    = 434,
    parameter int PARITY_ODD = 0
) (
    input  logic                      CLK,
    input  logic                      RST,
    uart_rx_control_module_if.slave   rx_bus
);

    localparam int            CW      = (BPS_DIV > 1) ? $clog2(BPS_DIV) : 1;
    localparam logic [CW-1:0] HALF_PT = CW'(BPS_DIV / 2);
    localparam logic [CW-1:0] FULL_PT = CW'(BPS_DIV - 1);
    localparam logic          P_ODD   = 1'(PARITY_ODD);
`ifdef UART_RX_PARITY_EN
    localparam logic          PAR_EN  = 1'b1;
`else
    localparam logic          PAR_EN  = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_sync1;
    logic          r_sync2;
    logic          r_prev;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_par_bit;
    logic [7:0]    r_data;
    logic          r_err;
    logic          w_start_edge;
    logic          w_tick;
    logic          w_par_err;

    // Sync flops reset to the idle level so reset release never looks like a start edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= rx_bus.RX_Pin_In;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_start_edge = r_prev & ~r_sync2;
    assign w_par_err    = PAR_EN & ((^r_shift ^ r_par_bit) != P_ODD);

    always_comb begin
        w_tick = 1'b0;
        case (r_state)
            S_START:                  w_tick = (r_cnt == HALF_PT);
            S_DATA, S_PARITY, S_STOP: w_tick = (r_cnt == FULL_PT);
            default:                  w_tick = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (rx_bus.RX_En_Sig && w_start_edge) w_next = S_START;
            end
            S_START: begin
                if (!rx_bus.RX_En_Sig) w_next = S_IDLE;
                else if (w_tick)       w_next = r_sync2 ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (!rx_bus.RX_En_Sig)                 w_next = S_IDLE;
                else if (w_tick && r_bit_idx == 3'd7)  w_next = PAR_EN ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (!rx_bus.RX_En_Sig) w_next = S_IDLE;
                else if (w_tick)       w_next = S_STOP;
            end
            S_STOP: begin
                if (!rx_bus.RX_En_Sig) w_next = S_IDLE;
                else if (w_tick)       w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output byte and error load on entry to DONE so they are valid alongside the done pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_par_bit <= 1'b0;
            r_data    <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_next != r_state || w_tick || r_state == S_IDLE) r_cnt <= '0;
            else                                                   r_cnt <= r_cnt + 1'b1;

            if (r_state != S_DATA) r_bit_idx <= '0;
            else if (w_tick)       r_bit_idx <= r_bit_idx + 1'b1;

            if (r_state == S_DATA && w_tick)   r_shift   <= {r_sync2, r_shift[7:1]};
            if (r_state == S_PARITY && w_tick) r_par_bit <= r_sync2;

            if (w_next == S_DONE) begin
                r_data <= r_shift;
                r_err  <= ~r_sync2 | w_par_err;
            end
        end
    end

    assign rx_bus.RX_Data     = r_data;
    assign rx_bus.RX_Err_Sig  = r_err;
    assign rx_bus.RX_Done_Sig = (r_state == S_DONE);
    assign rx_bus.RX_Busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_control_module.sv
// Scoreboard bench for uart_rx_control_module at BPS_DIV=16; parity frames only when UART_RX_PARITY_EN is defined.
module tb_uart_rx_control_module;

    localparam int   BPS     = 16;
    localparam logic PAR_ODD = 1'b0;
`ifdef UART_RX_PARITY_EN
    localparam int   FRAME_BITS = 11;
`else
    localparam int   FRAME_BITS = 10;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;
    int   cyc      = 0;
    int   t_prev   = 0;
    int   t_last   = 0;
    logic prev_done = 1'b0;
    logic [8:0] exp_q[$];

    uart_rx_control_module_if bus_if();

    uart_rx_control_module #(
        .BPS_DIV    (BPS),
        .PARITY_ODD (0)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .rx_bus (bus_if)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard side: every done pulse must match the oldest pushed expectation.
    always @(negedge CLK) begin
        logic [8:0] e;
        if (prev_done) check("done_one_cycle", bus_if.RX_Done_Sig, 1'b0);
        if (bus_if.RX_Done_Sig) begin
            n_done++;
            t_prev = t_last;
            t_last = cyc;
            check("done_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("rx_data", bus_if.RX_Data, e[7:0]);
                check("rx_err", bus_if.RX_Err_Sig, e[8]);
            end
        end
        prev_done = bus_if.RX_Done_Sig;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_bits(input logic [10:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            bus_if.RX_Pin_In = bits[i];
            idle(BPS);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
`ifdef UART_RX_PARITY_EN
        send_bits({stop, ^d ^ PAR_ODD, d, 1'b0}, 11);
`else
        send_bits({1'b0, stop, d, 1'b0}, 10);
`endif
    endtask

    task automatic drive_partial(input logic [7:0] d, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            int b;
            b = c / BPS;
            bus_if.RX_Pin_In = (b == 0) ? 1'b0 : d[b-1];
            @(negedge CLK);
        end
    endtask

    task automatic expect_done_count(input string tag, input int target);
        int budget;
        budget = 4 * BPS;
        while (n_done < target && budget > 0) begin
            @(negedge CLK);
            budget--;
        end
        check(tag, n_done, target);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bus_if.RX_En_Sig = 1'b1;
        bus_if.RX_Pin_In = 1'b1;
        idle(4);
        check("rst_data", bus_if.RX_Data, 8'h00);
        check("rst_done", bus_if.RX_Done_Sig, 1'b0);
        check("rst_err", bus_if.RX_Err_Sig, 1'b0);
        check("rst_busy", bus_if.RX_Busy, 1'b0);
        RST = 1'b0;
        idle(2 * BPS);

        // Plain good frame.
        exp_q.push_back({1'b0, 8'h55});
        send_frame(8'h55, 1'b1);
        expect_done_count("done_cnt_55", 1);
        check("busy_after_55", bus_if.RX_Busy, 1'b0);
        idle(BPS);

        // Short low glitch must be rejected at the start-bit mid sample.
        bus_if.RX_Pin_In = 1'b0;
        idle(4);
        bus_if.RX_Pin_In = 1'b1;
        idle(3 * BPS);
        check("glitch_no_done", n_done, 1);
        check("glitch_busy", bus_if.RX_Busy, 1'b0);
        check("glitch_data", bus_if.RX_Data, 8'h55);

        // Missing stop bit still delivers the byte, flagged.
        exp_q.push_back({1'b1, 8'hA5});
        send_frame(8'hA5, 1'b0);
        bus_if.RX_Pin_In = 1'b1;
        expect_done_count("done_cnt_a5_bad", 2);
        idle(2 * BPS);

        // Enable drop mid data bit 3: abort with outputs held.
        drive_partial(8'hF0, 4 * BPS + BPS / 2);
        bus_if.RX_En_Sig = 1'b0;
        bus_if.RX_Pin_In = 1'b1;
        @(negedge CLK);
        check("en_abort_busy", bus_if.RX_Busy, 1'b0);
        idle(3 * BPS);
        check("en_abort_no_done", n_done, 2);
        check("en_abort_data", bus_if.RX_Data, 8'hA5);
        check("en_abort_err", bus_if.RX_Err_Sig, 1'b1);
        bus_if.RX_En_Sig = 1'b1;
        idle(BPS);

        exp_q.push_back({1'b0, 8'h3C});
        send_frame(8'h3C, 1'b1);
        expect_done_count("done_cnt_3c", 3);
        exp_q.push_back({1'b0, 8'h81});
        send_frame(8'h81, 1'b1);
        expect_done_count("done_cnt_81a", 4);
        idle(BPS);

        // Back-to-back frames with no idle gap.
        exp_q.push_back({1'b0, 8'hA5});
        exp_q.push_back({1'b0, 8'h3C});
        send_frame(8'hA5, 1'b1);
        send_frame(8'h3C, 1'b1);
        expect_done_count("done_cnt_b2b", 6);
        check("b2b_spacing", t_last - t_prev, FRAME_BITS * BPS);
        idle(BPS);

        // Reset mid data bit 5 discards the frame and clears outputs.
        drive_partial(8'h6E, 6 * BPS + BPS / 2);
        RST = 1'b1;
        bus_if.RX_Pin_In = 1'b1;
        @(negedge CLK);
        check("rst_mid_busy", bus_if.RX_Busy, 1'b0);
        check("rst_mid_data", bus_if.RX_Data, 8'h00);
        check("rst_mid_err", bus_if.RX_Err_Sig, 1'b0);
        RST = 1'b0;
        idle(3 * BPS);
        check("rst_mid_no_done", n_done, 6);
        exp_q.push_back({1'b0, 8'h81});
        send_frame(8'h81, 1'b1);
        expect_done_count("done_cnt_81b", 7);
        idle(BPS);

        // Break: constant low yields exactly one errored zero frame.
        exp_q.push_back({1'b1, 8'h00});
        bus_if.RX_Pin_In = 1'b0;
        idle(3 * FRAME_BITS * BPS);
        check("break_one_frame", n_done, 8);
        bus_if.RX_Pin_In = 1'b1;
        idle(2 * BPS);
        check("break_no_extra", n_done, 8);
        exp_q.push_back({1'b0, 8'h55});
        send_frame(8'h55, 1'b1);
        expect_done_count("done_cnt_after_break", 9);
        idle(BPS);

`ifdef UART_RX_PARITY_EN
        base = n_done;
        exp_q.push_back({1'b0, 8'h07});
        send_bits({1'b1, 1'b1, 8'h07, 1'b0}, 11);
        expect_done_count("done_cnt_par_ok", base + 1);
        exp_q.push_back({1'b1, 8'h07});
        send_bits({1'b1, 1'b0, 8'h07, 1'b0}, 11);
        expect_done_count("done_cnt_par_bad", base + 2);
        idle(BPS);
`else
        base = n_done;
        check("final_done_cnt", base, 9);
`endif

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
